sprite_line_fetch: RTL and testbench
====================================

SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

Interface
REQ-001 Parameter NUM_SPRITES, 64: sprite attribute entries, 4 words each.
REQ-002 Parameter WIDTH, 640: visible line width in pixels.
REQ-003 Parameter SPRITE_ATTR_ADDR, 16'h4000: base of the memory-mapped attribute table (4*NUM_SPRITES words).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 line_start  in  1  one-cycle pulse; begin scanning for line `line_y`.
REQ-007 line_y  in  10  line number to be built.
REQ-008 busy  in  1  line-buffer stage still consuming the previous load.
REQ-009 load  out  1  one-cycle strobe; the slice fields below are valid.
REQ-010 addr  out  10  pixel x of the 4-pixel slice.
REQ-011 tile  out  12  tile-data word index for the slice.
REQ-012 z  out  2  sprite priority.
REQ-013 palette  out  4  sprite palette.
REQ-014 done  out  1  one-cycle pulse when the scan completes.
REQ-015 scanning  out  1  high from line_start until done.
REQ-016 memaddr  in  16, memwrite  in  1, writedata  in  16, memdata  out  16: CPU port to the attribute table.

Function
REQ-017 Attribute word0 SHALL be: [9:0] top y; [15:10] height-1 (1..64 lines).
REQ-018 Word1 SHALL be: [9:0] left x. Word2: [11:0] base tile. Word3: [15] enable, [13:12] z, [11:8] palette, [3:0] width-1 in 4-pixel words (1..16).
REQ-019 CPU access: when memaddr is in [SPRITE_ATTR_ADDR, SPRITE_ATTR_ADDR+4*NUM_SPRITES-1], memwrite writes that word; memdata returns the addressed word registered, 1-cycle latency. memdata holds its value outside the range.
REQ-020 FSM states: IDLE, FETCH, TEST, EMIT, HOLD, FINISH.
REQ-021 IDLE -> FETCH on line_start; sprite index = 0; line_y latched.
REQ-022 FETCH reads the 4 attribute words of the current sprite over 4 cycles (synchronous RAM, 1-cycle latency), then goes to TEST.
REQ-023 TEST: row = line_y - top_y, computed mod 2^10. Hit iff enable=1, z!=0, and row <= height-1. Hit -> EMIT with k=0; miss -> next sprite.
REQ-024 EMIT (busy=0): assert load for one cycle. addr = x + 4k, tile = base + row*(width) + k, with the tile sum truncated to 12 bits. Next state is HOLD.
REQ-025 HOLD: wait while busy=1. At the first cycle with busy=0: k+1 <= width-1 -> EMIT with k+1; otherwise -> next sprite.
REQ-026 EMIT is never entered while busy=1. Load SHALL never be asserted two cycles in a row.
REQ-027 Next sprite: index+1 < NUM_SPRITES -> FETCH; otherwise -> FINISH. FINISH pulses done for one cycle, then goes to IDLE.
REQ-028 Sprites are processed in ascending index order. Slices within a sprite are processed in ascending k.
REQ-029 addr is computed mod 2^10. x+4k wrapping past 1023 is emitted as wrapped unless REQ-034 applies.
REQ-030 line_start outside IDLE aborts the current scan: load is deasserted, done is not pulsed, and the next cycle restarts in FETCH with index 0 and the new line_y.
REQ-031 CPU writes during a scan take effect on the next word read. The table is single-port and the CPU port has priority. A scan FETCH cycle that collides with a CPU access stalls one cycle.

Reset
REQ-032 Reset asserted, at any time: state=IDLE; load=0, done=0, scanning=0, addr=0, tile=0, z=0, palette=0, memdata=0. Any in-progress scan is discarded.
REQ-033 Attribute contents are not reset.

Configuration
REQ-034 Macro SPRITE_HCULL_EN defined: slices with x+4k >= WIDTH (unwrapped 11-bit sum) are skipped without asserting load. A sprite whose x >= WIDTH is treated as a miss. Macro undefined: every slice is emitted per REQ-024/029.

Verification
REQ-035 Sprite 0: y=100, h=8, x=40, tile=0x010, w=2, z=2, pal=3, en=1; line_start with line_y=103. Expected: loads (addr 40, tile 0x016) then (44, 0x017), then done.
REQ-036 Same sprite with line_y=99 and with line_y=108. Expected: no load, done pulses.
REQ-037 Hold busy=1 for 5 cycles after the first load. Expected: second load only on the cycle after busy falls, never back-to-back.
REQ-038 x=636, w=2, SPRITE_HCULL_EN defined. Expected: only the addr 636 load. Macro undefined: addr 636 and 640 loads.
REQ-039 line_start pulsed mid-scan (during HOLD). Expected: no done for the old scan; rescan from sprite 0 with the new line_y.
REQ-040 rst asserted low during EMIT. Expected: load=0 immediately (asynchronous), state IDLE; CPU readback of a written attribute word is unchanged.

Source files
------------

// File: rtl/sprite_line_fetch.sv
// Sprite line fetch: scans the sprite attribute table for one display line
// and emits one load strobe per 4-pixel slice of every sprite on that line.
// The attribute table is a single-port RAM shared with a CPU port; the CPU
// has priority and a colliding scan read simply stalls for a cycle.
// Optional feature macro: SPRITE_HCULL_EN -- when defined, slices that start
// at or beyond the visible line width are skipped and sprites whose left x
// is off-screen are treated as misses.
module sprite_line_fetch #(
    parameter int          NUM_SPRITES      = 64,
    parameter int          WIDTH            = 640,
    parameter logic [15:0] SPRITE_ATTR_ADDR = 16'h4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic        busy,
    output logic        load,
    output logic [9:0]  addr,
    output logic [11:0] tile,
    output logic [1:0]  z,
    output logic [3:0]  palette,
    output logic        done,
    output logic        scanning,
    input  logic [15:0] memaddr,
    input  logic        memwrite,
    input  logic [15:0] writedata,
    output logic [15:0] memdata
);

    localparam int IW    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int AW    = IW + 2;
    localparam int DEPTH = 4 * NUM_SPRITES;
    localparam logic [16:0] ATTR_END = 17'(SPRITE_ATTR_ADDR) + 17'(DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, TEST, EMIT, HOLD, FINISH} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [1:0]      fcnt_reg, fcnt_next;
    logic [3:0]      k_reg, k_next;
    logic [9:0]      line_y_reg, line_y_next;
    logic [11:0]     tile_base_reg, tile_base_next;
    logic            rd_valid_reg;
    logic [1:0]      rd_word_reg;

    // Captured attribute fields of the sprite under test
    logic [9:0]      top_reg;
    logic [5:0]      hm1_reg;
    logic [9:0]      x_reg;
    logic [11:0]     base_reg;
    logic            en_reg;
    logic [1:0]      z_reg;
    logic [3:0]      pal_reg;
    logic [3:0]      wm1_reg;

    // Attribute RAM and its single shared port
    logic [15:0]     attr_mem [0:DEPTH-1];
    logic [15:0]     rd_data_reg;
    logic            cpu_hit;
    logic            scan_rd;
    logic [AW-1:0]   port_addr;
    logic            cpu_rd_reg;
    logic [15:0]     memdata_hold_reg;

    logic            cull_en;
    logic            en_v;
    logic [1:0]      z_v;
    logic [3:0]      wm1_v;
    logic [9:0]      row;
    logic [10:0]     row_prod;
    logic [11:0]     tile_base_calc;
    logic            x_ok;
    logic            hit;
    logic [4:0]      k_plus1;
    logic [10:0]     next_addr11;
    logic            next_more;
    logic            next_vis;
    logic            last_sprite;
    logic            advance;

`ifdef SPRITE_HCULL_EN
    assign cull_en = 1'b1;
`else
    assign cull_en = 1'b0;
`endif

    assign cpu_hit   = (memaddr >= SPRITE_ATTR_ADDR) && ({1'b0, memaddr} < ATTR_END);
    assign port_addr = cpu_hit ? AW'(memaddr - SPRITE_ATTR_ADDR) : {idx_reg, fcnt_reg};

    // Single-port attribute RAM, read-first, CPU address wins the port
    always_ff @(posedge clk) begin
        if (cpu_hit && memwrite) begin
            attr_mem[port_addr] <= writedata;
        end
        rd_data_reg <= attr_mem[port_addr];
    end

    // CPU readback: live RAM data after an in-range access, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rd_reg       <= 1'b0;
            memdata_hold_reg <= 16'h0000;
        end else begin
            cpu_rd_reg <= cpu_hit;
            if (cpu_rd_reg) begin
                memdata_hold_reg <= rd_data_reg;
            end
        end
    end

    assign memdata = cpu_rd_reg ? rd_data_reg : memdata_hold_reg;

    // Word 3 arrives from the RAM during the first TEST cycle; use it directly there
    assign en_v  = rd_valid_reg ? rd_data_reg[15]    : en_reg;
    assign z_v   = rd_valid_reg ? rd_data_reg[13:12] : z_reg;
    assign wm1_v = rd_valid_reg ? rd_data_reg[3:0]   : wm1_reg;

    assign row            = line_y_reg - top_reg;
    assign row_prod       = {5'b0, row[5:0]} * {6'b0, ({1'b0, wm1_v} + 5'd1)};
    assign tile_base_calc = base_reg + {1'b0, row_prod};
    assign x_ok           = !cull_en || ({1'b0, x_reg} < 11'(WIDTH));
    assign hit            = en_v && (z_v != 2'b00) && (row <= {4'b0, hm1_reg}) && x_ok;

    // Slices leave the screen monotonically, so the first culled slice ends the sprite
    assign k_plus1     = {1'b0, k_reg} + 5'd1;
    assign next_more   = (k_plus1 <= {1'b0, wm1_reg});
    assign next_addr11 = {1'b0, x_reg} + {4'b0, k_plus1, 2'b00};
    assign next_vis    = !cull_en || (next_addr11 < 11'(WIDTH));
    assign last_sprite = (idx_reg == IW'(NUM_SPRITES - 1));

    // Scan state and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            fcnt_reg      <= 2'd0;
            k_reg         <= 4'd0;
            line_y_reg    <= 10'd0;
            tile_base_reg <= 12'd0;
            rd_valid_reg  <= 1'b0;
            rd_word_reg   <= 2'd0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            fcnt_reg      <= fcnt_next;
            k_reg         <= k_next;
            line_y_reg    <= line_y_next;
            tile_base_reg <= tile_base_next;
            rd_valid_reg  <= scan_rd;
            rd_word_reg   <= fcnt_reg;
        end
    end

    // Capture each attribute word one cycle after its scan read was issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_reg  <= 10'd0;
            hm1_reg  <= 6'd0;
            x_reg    <= 10'd0;
            base_reg <= 12'd0;
            en_reg   <= 1'b0;
            z_reg    <= 2'd0;
            pal_reg  <= 4'd0;
            wm1_reg  <= 4'd0;
        end else if (rd_valid_reg) begin
            case (rd_word_reg)
                2'd0: begin
                    top_reg <= rd_data_reg[9:0];
                    hm1_reg <= rd_data_reg[15:10];
                end
                2'd1: x_reg    <= rd_data_reg[9:0];
                2'd2: base_reg <= rd_data_reg[11:0];
                default: begin
                    en_reg  <= rd_data_reg[15];
                    z_reg   <= rd_data_reg[13:12];
                    pal_reg <= rd_data_reg[11:8];
                    wm1_reg <= rd_data_reg[3:0];
                end
            endcase
        end
    end

    // Next-state logic; line_start always restarts the scan from sprite 0
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        fcnt_next      = fcnt_reg;
        k_next         = k_reg;
        line_y_next    = line_y_reg;
        tile_base_next = tile_base_reg;
        scan_rd        = 1'b0;
        advance        = 1'b0;
        if (line_start) begin
            state_next  = FETCH;
            idx_next    = '0;
            fcnt_next   = 2'd0;
            k_next      = 4'd0;
            line_y_next = line_y;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                FETCH: begin
                    if (!cpu_hit) begin
                        scan_rd   = 1'b1;
                        fcnt_next = fcnt_reg + 2'd1;
                        if (fcnt_reg == 2'd3) begin
                            state_next = TEST;
                        end
                    end
                end
                TEST: begin
                    tile_base_next = tile_base_calc;
                    if (hit) begin
                        if (!busy) begin
                            state_next = EMIT;
                            k_next     = 4'd0;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                EMIT: state_next = HOLD;
                HOLD: begin
                    if (!busy) begin
                        if (next_more && next_vis) begin
                            state_next = EMIT;
                            k_next     = k_plus1[3:0];
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                FINISH:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
            if (advance) begin
                if (last_sprite) begin
                    state_next = FINISH;
                end else begin
                    state_next = FETCH;
                    idx_next   = idx_reg + IW'(1);
                    fcnt_next  = 2'd0;
                end
            end
        end
    end

    // Output strobes and slice fields; fields read zero outside a load
    always_comb begin
        load     = (state_reg == EMIT) && !line_start;
        done     = (state_reg == FINISH) && !line_start;
        scanning = (state_reg != IDLE);
        addr     = 10'd0;
        tile     = 12'd0;
        z        = 2'd0;
        palette  = 4'd0;
        if (load) begin
            addr    = x_reg + {4'b0, k_reg, 2'b00};
            tile    = tile_base_reg + {8'b0, k_reg};
            z       = z_reg;
            palette = pal_reg;
        end
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Self-checking bench for sprite_line_fetch: a table of single-sprite line
// scans plus directed sequences for busy back-pressure, scan abort, sprite
// ordering, CPU port behaviour and asynchronous reset.
module tb_sprite_line_fetch;

    logic        clk;
    logic        rst;
    logic        line_start;
    logic [9:0]  line_y;
    logic        busy;
    logic        load;
    logic [9:0]  addr;
    logic [11:0] tile;
    logic [1:0]  z;
    logic [3:0]  palette;
    logic        done;
    logic        scanning;
    logic [15:0] memaddr;
    logic        memwrite;
    logic [15:0] writedata;
    logic [15:0] memdata;

    sprite_line_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .line_y     (line_y),
        .busy       (busy),
        .load       (load),
        .addr       (addr),
        .tile       (tile),
        .z          (z),
        .palette    (palette),
        .done       (done),
        .scanning   (scanning),
        .memaddr    (memaddr),
        .memwrite   (memwrite),
        .writedata  (writedata),
        .memdata    (memdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [11:0] tile;
        logic [1:0]  z;
        logic [3:0]  pal;
    } load_t;

    typedef struct {
        logic [9:0]  top;
        logic [5:0]  hm1;
        logic [9:0]  x;
        logic [11:0] base;
        logic        en;
        logic [1:0]  zz;
        logic [3:0]  pal;
        logic [3:0]  wm1;
        logic [9:0]  line;
        int          nloads;
        logic [9:0]  a_first;
        logic [11:0] t_first;
        logic [9:0]  a_last;
        logic [11:0] t_last;
    } vec_t;

    int    total_cnt = 0;
    int    pass_cnt  = 0;
    int    cyc_cnt   = 0;
    int    done_cnt  = 0;
    int    b2b_cnt   = 0;
    int    busy_load_cnt = 0;
    logic  prev_load = 1'b0;
    load_t load_q[$];

    always @(posedge clk) cyc_cnt++;

    // Monitor: record every load and done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            if (load) begin
                load_q.push_back('{cyc_cnt, addr, tile, z, palette});
                $display("load cyc=%0d addr=%0d tile=%03h z=%0d pal=%0d", cyc_cnt, addr, tile, z, palette);
                if (prev_load) b2b_cnt++;
                if (busy) busy_load_cnt++;
            end
            if (done) done_cnt++;
            prev_load = load;
        end else begin
            prev_load = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        memaddr   = a;
        memwrite  = 1'b1;
        writedata = d;
        cyc();
        memwrite  = 1'b0;
        memaddr   = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        memaddr  = a;
        memwrite = 1'b0;
        cyc();
        #1;
        d = memdata;
        memaddr = 16'h0000;
    endtask

    function automatic logic [15:0] word3(input logic en, input logic [1:0] zz,
                                          input logic [3:0] pal, input logic [3:0] wm1);
        return {en, 1'b0, zz, pal, 4'b0000, wm1};
    endfunction

    task automatic set_sprite(input int idx, input logic [9:0] top, input logic [5:0] hm1,
                              input logic [9:0] x, input logic [11:0] base, input logic en,
                              input logic [1:0] zz, input logic [3:0] pal, input logic [3:0] wm1);
        logic [15:0] a;
        a = 16'h4000 + 16'(4 * idx);
        cpu_write(a,         {hm1, top});
        cpu_write(a + 16'd1, {6'b0, x});
        cpu_write(a + 16'd2, {4'b0, base});
        cpu_write(a + 16'd3, word3(en, zz, pal, wm1));
    endtask

    task automatic start_scan(input logic [9:0] ly, output int ls_cyc);
        load_q.delete();
        done_cnt      = 0;
        b2b_cnt       = 0;
        busy_load_cnt = 0;
        line_y        = ly;
        line_start    = 1'b1;
        ls_cyc        = cyc_cnt;
        cyc();
        line_start    = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000; n++) begin
            if (done_cnt > 0) break;
            cyc();
        end
        cyc();
    endtask

    task automatic wait_load(output logic seen);
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (load) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    vec_t vecs[12];

    initial begin
        int          ls;
        int          e;
        int          qsz;
        logic        seen;
        logic [15:0] rd;

        vecs[0]  = '{10'd100, 6'd7, 10'd40, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd103, 2, 10'd40, 12'h016, 10'd44, 12'h017};
        vecs[1]  = '{10'd100, 6'd7, 10'd40, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd99,  0, 10'd0,  12'h000, 10'd0,  12'h000};
        vecs[2]  = '{10'd100, 6'd7, 10'd40, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd108, 0, 10'd0,  12'h000, 10'd0,  12'h000};
        vecs[3]  = '{10'd100, 6'd7, 10'd40, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd100, 2, 10'd40, 12'h010, 10'd44, 12'h011};
        vecs[4]  = '{10'd100, 6'd7, 10'd40, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd107, 2, 10'd40, 12'h01E, 10'd44, 12'h01F};
        vecs[5]  = '{10'd100, 6'd7, 10'd40, 12'h010, 1'b1, 2'd0, 4'd3, 4'd1, 10'd103, 0, 10'd0,  12'h000, 10'd0,  12'h000};
        vecs[6]  = '{10'd100, 6'd7, 10'd40, 12'h010, 1'b0, 2'd2, 4'd3, 4'd1, 10'd103, 0, 10'd0,  12'h000, 10'd0,  12'h000};
`ifdef SPRITE_HCULL_EN
        vecs[7]  = '{10'd100, 6'd7, 10'd636, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd103, 1, 10'd636, 12'h016, 10'd636, 12'h016};
        vecs[8]  = '{10'd100, 6'd7, 10'd1022, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd103, 0, 10'd0, 12'h000, 10'd0, 12'h000};
`else
        vecs[7]  = '{10'd100, 6'd7, 10'd636, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd103, 2, 10'd636, 12'h016, 10'd640, 12'h017};
        vecs[8]  = '{10'd100, 6'd7, 10'd1022, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1, 10'd103, 2, 10'd1022, 12'h016, 10'd2, 12'h017};
`endif
        vecs[9]  = '{10'd100, 6'd7, 10'd40, 12'hFFE, 1'b1, 2'd2, 4'd3, 4'd1, 10'd103, 2, 10'd40, 12'h004, 10'd44, 12'h005};
        vecs[10] = '{10'd0, 6'd63, 10'd0, 12'h000, 1'b1, 2'd1, 4'd15, 4'd15, 10'd63, 16, 10'd0, 12'h3F0, 10'd60, 12'h3FF};
        vecs[11] = '{10'd1020, 6'd7, 10'd100, 12'h100, 1'b1, 2'd3, 4'd0, 4'd0, 10'd2, 1, 10'd100, 12'h106, 10'd100, 12'h106};

        rst        = 1'b1;
        line_start = 1'b0;
        line_y     = 10'd0;
        busy       = 1'b0;
        memaddr    = 16'h0000;
        memwrite   = 1'b0;
        writedata  = 16'h0000;
        #1 rst = 1'b0;
        #2;
        check("reset_load",     32'(load),     32'h0);
        check("reset_done",     32'(done),     32'h0);
        check("reset_scanning", 32'(scanning), 32'h0);
        check("reset_addr",     32'(addr),     32'h0);
        check("reset_tile",     32'(tile),     32'h0);
        check("reset_memdata",  32'(memdata),  32'h0);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        for (int i = 0; i < 256; i++) cpu_write(16'h4000 + 16'(i), 16'h0000);

        // CPU port: readback, hold outside range, range boundaries
        cpu_write(16'h4005, 16'hBEEF);
        cpu_read(16'h4005, rd);
        check("cpu_readback", 32'(rd), 32'hBEEF);
        cyc(); cyc(); #1;
        check("cpu_hold_outside", 32'(memdata), 32'hBEEF);
        cpu_write(16'h40FF, 16'h1234);
        cpu_write(16'h4100, 16'h5555);
        cpu_read(16'h40FF, rd);
        check("cpu_last_word", 32'(rd), 32'h1234);
        cpu_read(16'h4000, rd);
        check("cpu_no_alias", 32'(rd), 32'h0000);
        cpu_write(16'h4005, 16'h0000);
        cpu_write(16'h40FF, 16'h0000);

        // Table-driven single-sprite scans
        for (int i = 0; i < 12; i++) begin
            set_sprite(0, vecs[i].top, vecs[i].hm1, vecs[i].x, vecs[i].base, vecs[i].en,
                       vecs[i].zz, vecs[i].pal, vecs[i].wm1);
            start_scan(vecs[i].line, ls);
            wait_done();
            check($sformatf("v%0d_nloads", i), 32'(load_q.size()), 32'(vecs[i].nloads));
            check($sformatf("v%0d_done", i), 32'(done_cnt), 32'd1);
            check($sformatf("v%0d_b2b", i), 32'(b2b_cnt), 32'd0);
            if (vecs[i].nloads > 0 && load_q.size() > 0) begin
                check($sformatf("v%0d_addr_first", i), 32'(load_q[0].addr), 32'(vecs[i].a_first));
                check($sformatf("v%0d_tile_first", i), 32'(load_q[0].tile), 32'(vecs[i].t_first));
                check($sformatf("v%0d_addr_last", i), 32'(load_q[load_q.size()-1].addr), 32'(vecs[i].a_last));
                check($sformatf("v%0d_tile_last", i), 32'(load_q[load_q.size()-1].tile), 32'(vecs[i].t_last));
                check($sformatf("v%0d_z", i), 32'(load_q[0].z), 32'(vecs[i].zz));
                check($sformatf("v%0d_pal", i), 32'(load_q[0].pal), 32'(vecs[i].pal));
            end
            if (i == 0 && load_q.size() > 0) begin
                check("first_load_latency", 32'(load_q[0].cyc - ls), 32'd6);
            end
        end

        // Busy back-pressure after the first load
        set_sprite(0, 10'd100, 6'd7, 10'd40, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1);
        start_scan(10'd103, ls);
        wait_load(seen);
        check("busy_first_load_seen", 32'(seen), 32'd1);
        e = cyc_cnt;
        cyc();
        busy = 1'b1;
        repeat (5) cyc();
        busy = 1'b0;
        wait_done();
        check("busy_nloads", 32'(load_q.size()), 32'd2);
        if (load_q.size() == 2) begin
            check("busy_second_cycle", 32'(load_q[1].cyc - e), 32'd7);
            check("busy_second_tile", 32'(load_q[1].tile), 32'h017);
        end
        check("busy_no_load_while_busy", 32'(busy_load_cnt), 32'd0);
        check("busy_b2b", 32'(b2b_cnt), 32'd0);

        // Abort a scan in HOLD with a new line_start
        start_scan(10'd103, ls);
        wait_load(seen);
        check("abort_first_load_seen", 32'(seen), 32'd1);
        cyc();
        busy = 1'b1;
        cyc();
        #1;
        check("abort_scanning_in_hold", 32'(scanning), 32'd1);
        cyc();
        busy       = 1'b0;
        line_y     = 10'd100;
        line_start = 1'b1;
        ls         = cyc_cnt;
        cyc();
        line_start = 1'b0;
        wait_done();
        check("abort_done_count", 32'(done_cnt), 32'd1);
        check("abort_nloads", 32'(load_q.size()), 32'd3);
        if (load_q.size() == 3) begin
            check("abort_old_tile", 32'(load_q[0].tile), 32'h016);
            check("abort_new_tile0", 32'(load_q[1].tile), 32'h010);
            check("abort_new_tile1", 32'(load_q[2].tile), 32'h011);
            check("abort_restart_latency", 32'(load_q[1].cyc - ls), 32'd6);
        end

        // Ascending sprite order
        cpu_write(16'h4003, 16'h0000);
        set_sprite(3, 10'd0, 6'd63, 10'd300, 12'h300, 1'b1, 2'd1, 4'd2, 4'd0);
        set_sprite(1, 10'd0, 6'd63, 10'd200, 12'h200, 1'b1, 2'd1, 4'd1, 4'd0);
        start_scan(10'd10, ls);
        wait_done();
        check("order_nloads", 32'(load_q.size()), 32'd2);
        if (load_q.size() == 2) begin
            check("order_first_addr", 32'(load_q[0].addr), 32'd200);
            check("order_first_tile", 32'(load_q[0].tile), 32'h20A);
            check("order_second_addr", 32'(load_q[1].addr), 32'd300);
            check("order_second_tile", 32'(load_q[1].tile), 32'h30A);
        end

        // Asynchronous reset in the middle of EMIT
        set_sprite(0, 10'd100, 6'd7, 10'd40, 12'h010, 1'b1, 2'd2, 4'd3, 4'd1);
        cpu_read(16'h4001, rd);
        check("rst_pre_read", 32'(rd), 32'd40);
        start_scan(10'd103, ls);
        wait_load(seen);
        check("rst_load_seen", 32'(seen), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_load_now",     32'(load),     32'd0);
        check("rst_scanning_now", 32'(scanning), 32'd0);
        check("rst_addr_now",     32'(addr),     32'd0);
        check("rst_memdata_now",  32'(memdata),  32'd0);
        qsz = load_q.size();
        cyc(); cyc();
        rst = 1'b1;
        repeat (20) cyc();
        check("rst_no_more_loads", 32'(load_q.size()), 32'(qsz));
        check("rst_no_done", 32'(done_cnt), 32'd0);
        cpu_read(16'h4003, rd);
        check("rst_attr_word3", 32'(rd), 32'hA301);
        cpu_read(16'h4000, rd);
        check("rst_attr_word0", 32'(rd), 32'h1C64);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
